dp_ram_sync: RTL
================

Name: dp_ram_sync

Overview:
Single-clock, two-port synchronous RAM. It is the parametrised successor of the team's dual-port RAM and adds:
- configurable read-during-write mode
- deterministic write-collision arbitration with a collision flag
- an optional output register stage
- read-valid strobes
- a post-reset initialisation sweep that clears every word.

It is the common storage primitive for FIFOs, register files and buffers in the memory examples.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 4: address width in bits.
- RAM_DEPTH, 1<<ADDR_WIDTH: number of words. May be less than 2**ADDR_WIDTH.
- RDW_MODE, 0: read-during-write result. 0 = old data (read-first), 1 = new data (write-first).
- OUT_REG, 0: 1 adds one output pipeline stage.
- COLL_PRIO, 0: winner when both ports write the same address. 0 = port A, 1 = port B.
- INIT_VALUE, 0: DATA_WIDTH-bit value written to every word during the init sweep.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- wea, in, 1: port A write enable, active-high.
- rea, in, 1: port A read enable, active-high.
- addra, in, ADDR_WIDTH: port A address.
- dina, in, DATA_WIDTH: port A write data.
- web, in, 1: port B write enable, active-high.
- reb, in, 1: port B read enable, active-high.
- addrb, in, ADDR_WIDTH: port B address.
- dinb, in, DATA_WIDTH: port B write data.
- douta, out, DATA_WIDTH: port A read data.
- doutb, out, DATA_WIDTH: port B read data.
- rvalida, out, 1: douta updated this cycle (one-cycle pulse).
- rvalidb, out, 1: doutb updated this cycle (one-cycle pulse).
- ready, out, 1: initialisation complete; requests are accepted.
- coll, out, 1: same-address write collision occurred (one-cycle pulse).
- addr_err, out, 1: an enabled access used an address >= RAM_DEPTH (one-cycle pulse).

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.

Reset:
- rst sampled high at a clock edge sets: douta=0, doutb=0, rvalida=0, rvalidb=0, ready=0, coll=0, addr_err=0, pipeline stage cleared, FSM to INIT, init counter=0.
- Reset asserted mid-INIT or mid-RUN restarts the sweep from address 0. Any in-flight reads are dropped, with no rvalid.

FSM states: INIT and RUN.
- INIT: writes INIT_VALUE to mem[cnt] each cycle and increments cnt. On the edge that writes address RAM_DEPTH-1, goes to RUN and ready rises.
- The sweep takes exactly RAM_DEPTH cycles after rst is deasserted.
- In INIT, all port enables are ignored: no writes, no rvalid, coll=0, addr_err=0.
- RUN: normal operation. RUN is left only via rst.

Latency:
- A read enabled at edge N (re=1 and ready=1) updates dout and pulses rvalid at edge N+1-... precisely: at edge N when OUT_REG=0, at edge N+1 when OUT_REG=1.
- A port with no read holds its dout value; its rvalid=0.
- With OUT_REG=1 the stage advances every cycle. Back-to-back reads give one result per cycle.

Write:
- The write is committed at edge N.
- A same-port read and write at one address returns the old word when RDW_MODE=0, or din when RDW_MODE=1.

Cross-port:
- Port X reads the address port Y writes in the same cycle: the same RDW_MODE rule applies, using Y's din.
- Both ports write the same address:
  - only the COLL_PRIO winner's data is stored;
  - coll pulses high on the next cycle;
  - a read on either port with RDW_MODE=1 returns the winner's data.
- Writes to different addresses both commit. Simultaneous reads of any addresses are always allowed.

Address range:
- An address >= RAM_DEPTH makes that port's write be dropped.
- A read at such an address returns 0 with rvalid=1.
- addr_err pulses one cycle after the access. Both ports can raise it in the same cycle; it is a single OR'd flag.

Widths:
- The init counter is ADDR_WIDTH+1 bits so RAM_DEPTH=2**ADDR_WIDTH terminates without wrap.
- Address comparisons are unsigned.

Decomposition:
- Package dp_ram_pkg holds:
  - FSM state enum (ST_INIT, ST_RUN)
  - RDW_OLD/RDW_NEW constants
  - PRIO_A/PRIO_B constants
- One natural sub-module: dp_ram_port_rd.
  - Instantiated twice.
  - Per-port read-data select: memory, bypass or zero.
  - Holds the dout register, the optional OUT_REG stage and the rvalid pipeline.
- The memory array, arbitration and FSM stay in the top.

Test Plan:
1. Init sweep: pulse rst for 1 cycle with DATA_WIDTH=8, ADDR_WIDTH=4, INIT_VALUE=8'hA5 -> ready=0 for exactly 16 cycles then 1. Reads of addresses 0..15 all return 8'hA5; rea asserted during INIT gives no rvalida.
2. Latency: write 8'h3C to A addr 2, then read it on B with OUT_REG=0 -> doutb=8'h3C and rvalidb at the next edge. With OUT_REG=1 both appear one edge later; back-to-back reads of addrs 0,1,2 give one result per cycle.
3. Read-during-write: mem[5]=8'h11; same cycle, wea=1 dina=8'h22 addra=5 and reb=1 addrb=5 -> doutb=8'h11 when RDW_MODE=0, 8'h22 when RDW_MODE=1. Repeat same-port (rea=1 with wea=1).
4. Collision: wea=web=1, addr 7, dina=8'hAA, dinb=8'h55 -> coll pulses once. With COLL_PRIO=0 a later read gives 8'hAA; with COLL_PRIO=1 it gives 8'h55.
5. Address range: RAM_DEPTH=12, write 8'hFF to addr 13 -> addr_err pulses, no array word changes. A read of addr 13 returns 0 with rvalid=1.
6. Reset mid-op: assert rst at INIT cycle 6, and again in RUN with a read in flight (OUT_REG=1) -> all outputs 0, no rvalid for the dropped read, full 16-cycle sweep restarts from 0.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the dual-port synchronous RAM.
package dp_ram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  localparam int unsigned PRIO_A = 0;
  localparam int unsigned PRIO_B = 1;

endpackage

// File: rtl/dp_ram_port_rd.sv
// Per-port read path: selects memory, bypass or zero data and owns the dout/rvalid pipeline.
module dp_ram_port_rd
  import dp_ram_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned RdwMode   = RDW_OLD,
  parameter int unsigned OutReg    = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 re_i,
  input  logic                 addr_ok_i,
  input  logic                 byp_hit_i,
  input  logic [DataWidth-1:0] byp_data_i,
  input  logic [DataWidth-1:0] mem_data_i,
  output logic [DataWidth-1:0] dout_o,
  output logic                 rvalid_o
);

  logic [DataWidth-1:0] rd_data;
  logic [DataWidth-1:0] dout_d, dout_q;
  logic                 rvalid_d, rvalid_q;

  always_comb begin
    rd_data = mem_data_i;
    if (!addr_ok_i) begin
      rd_data = '0;
    end else if ((RdwMode == RDW_NEW) && byp_hit_i) begin
      rd_data = byp_data_i;
    end
  end

  if (OutReg != 0) begin : g_out_reg
    logic [DataWidth-1:0] stg_data_q;
    logic                 stg_valid_q;

    always_comb begin
      dout_d   = dout_q;
      rvalid_d = stg_valid_q;
      if (stg_valid_q) begin
        dout_d = stg_data_q;
      end
    end

    // The stage advances every cycle so back-to-back reads stream at full rate.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stg_data_q  <= '0;
        stg_valid_q <= 1'b0;
      end else begin
        stg_data_q  <= rd_data;
        stg_valid_q <= re_i;
      end
    end
  end else begin : g_no_out_reg
    always_comb begin
      dout_d   = dout_q;
      rvalid_d = re_i;
      if (re_i) begin
        dout_d = rd_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign dout_o   = dout_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/dp_ram_sync.sv
// Single-clock two-port RAM with init sweep, write-collision arbitration and RDW control.
module dp_ram_sync
  import dp_ram_pkg::*;
#(
  parameter int unsigned               DATA_WIDTH = 8,
  parameter int unsigned               ADDR_WIDTH = 4,
  parameter int unsigned               RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int unsigned               RDW_MODE   = RDW_OLD,
  parameter int unsigned               OUT_REG    = 0,
  parameter int unsigned               COLL_PRIO  = PRIO_A,
  parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wea,
  input  logic                  rea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  web,
  input  logic                  reb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] douta,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  rvalida,
  output logic                  rvalidb,
  output logic                  ready,
  output logic                  coll,
  output logic                  addr_err
);

  localparam logic [ADDR_WIDTH:0] DepthW  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LastCnt = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  state_e              state_d, state_q;
  logic [ADDR_WIDTH:0] cnt_d, cnt_q;
  logic                coll_d, coll_q;
  logic                addr_err_d, addr_err_q;

  logic                  run;
  logic                  a_ok, b_ok;
  logic                  same_wr;
  logic                  wa_en, wb_en;
  logic [ADDR_WIDTH-1:0] rd_idx_a, rd_idx_b;
  logic [DATA_WIDTH-1:0] mem_rd_a, mem_rd_b;
  logic                  byp_hit_a, byp_hit_b;
  logic [DATA_WIDTH-1:0] byp_data_a, byp_data_b;

  assign run  = (state_q == ST_RUN);
  assign a_ok = ({1'b0, addra} < DepthW);
  assign b_ok = ({1'b0, addrb} < DepthW);

  // Arbitration: on a same-address double write only the priority port commits.
  assign same_wr = wea && web && a_ok && b_ok && (addra == addrb);
  assign wa_en   = run && wea && a_ok && !(same_wr && (COLL_PRIO == PRIO_B));
  assign wb_en   = run && web && b_ok && !(same_wr && (COLL_PRIO == PRIO_A));

  // Write-first bypass: the word this cycle's committed write leaves at the read address.
  always_comb begin
    byp_hit_a  = wa_en || (wb_en && (addrb == addra));
    byp_data_a = dina;
    if (wb_en && (addrb == addra)) begin
      byp_data_a = dinb;
    end
    byp_hit_b  = wb_en || (wa_en && (addra == addrb));
    byp_data_b = dinb;
    if (wa_en && (addra == addrb)) begin
      byp_data_b = dina;
    end
  end

  assign rd_idx_a = a_ok ? addra : '0;
  assign rd_idx_b = b_ok ? addrb : '0;
  assign mem_rd_a = mem[rd_idx_a];
  assign mem_rd_b = mem[rd_idx_b];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    coll_d     = 1'b0;
    addr_err_d = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        coll_d     = same_wr;
        addr_err_d = ((wea || rea) && !a_ok) || ((web || reb) && !b_ok);
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      coll_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      coll_q     <= coll_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Storage has no reset; the sweep after every reset establishes its contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem[cnt_q[ADDR_WIDTH-1:0]] <= INIT_VALUE;
      end else begin
        if (wa_en) begin
          mem[addra] <= dina;
        end
        if (wb_en) begin
          mem[addrb] <= dinb;
        end
      end
    end
  end

  dp_ram_port_rd #(
    .DataWidth (DATA_WIDTH),
    .RdwMode   (RDW_MODE),
    .OutReg    (OUT_REG)
  ) u_rd_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .re_i       (run && rea),
    .addr_ok_i  (a_ok),
    .byp_hit_i  (byp_hit_a),
    .byp_data_i (byp_data_a),
    .mem_data_i (mem_rd_a),
    .dout_o     (douta),
    .rvalid_o   (rvalida)
  );

  dp_ram_port_rd #(
    .DataWidth (DATA_WIDTH),
    .RdwMode   (RDW_MODE),
    .OutReg    (OUT_REG)
  ) u_rd_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .re_i       (run && reb),
    .addr_ok_i  (b_ok),
    .byp_hit_i  (byp_hit_b),
    .byp_data_i (byp_data_b),
    .mem_data_i (mem_rd_b),
    .dout_o     (doutb),
    .rvalid_o   (rvalidb)
  );

  assign ready    = run;
  assign coll     = coll_q;
  assign addr_err = addr_err_q;

endmodule
